mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single SRAM-like memory port between the instruction-fetch requester (IF) and the data requester (MEM). It sequences one outstanding bus transaction at a time. It generates `stallreq_from_if` and `stallreq_from_mem` for the hazard unit, and holds each returned word until the stalled pipeline advances. It sits between the pipeline stages and the bus bridge.

## Interface
Parameters:
- none (widths fixed by the 32-bit MIPS datapath)

Ports:
- `clk`  in  1  core clock; one clock domain
- `rst`  in  1  reset, synchronous, active-high
- `inst_req`  in  1  IF requests a fetch
- `inst_addr`  in  32  fetch address
- `inst_rdata`  out  32  fetched word, valid while the inst done-flag is set
- `data_req`  in  1  MEM requests a load or store
- `data_wr`  in  1  1 = store
- `data_size`  in  2  0 = byte, 1 = half, 2 = word
- `data_addr`  in  32  data address
- `data_wdata`  in  32  store data
- `data_rdata`  out  32  load word, valid while the data done-flag is set
- `cpu_stall`  in  1  global pipeline stall (OR of all stage stalls)
- `flush`  in  1  exception flush
- `stallreq_from_if`  out  1  = `inst_req & ~inst_done`
- `stallreq_from_mem`  out  1  = `data_req & ~data_done`
- `bus_req`, `bus_wr`  out  1 each  bus request / write
- `bus_size`  out  2  bus size
- `bus_addr`, `bus_wdata`  out  32 each  bus address / write data
- `bus_addr_ok`, `bus_data_ok`  in  1 each  address accepted / data returned
- `bus_rdata`  in  32  bus read data

## Operation
- FSM states: IDLE, ADDR, WAIT. Owner register: INST or DATA.
- IDLE:
  - Pending means `req & ~done`.
  - If `flush` is high, no grant is made that cycle.
  - Otherwise, if DATA is pending, latch the data request fields, set owner = DATA, go to ADDR.
  - Otherwise, if INST is pending, latch `inst_addr` with wr = 0 and size = 2, set owner = INST, go to ADDR.
- ADDR:
  - `bus_req` = 1; bus fields come from the latched registers.
  - On `bus_addr_ok`, go to WAIT.
  - `bus_data_ok` is ignored in ADDR; the slave guarantees at least one cycle between address acceptance and data return.
- WAIT:
  - On `bus_data_ok`, if kill = 0, capture `bus_rdata` into the owner's result register and set the owner's done-flag.
  - Then go to IDLE and clear kill.
- Flush:
  - `flush` clears both done-flags.
  - If the FSM is in ADDR or WAIT, set kill. The in-flight transaction is drained, never aborted, and its data is discarded.
- Done-flag clear:
  - Both done-flags clear on any edge where `cpu_stall` = 0, i.e. the pipeline advances.
  - Set takes precedence over clear in the same cycle. The flag clears at the first later edge with `cpu_stall` low.
- The CPU deasserts `data_req` for excepting instructions. The arbiter never re-checks exceptions.
- Stores: the result register is unchanged, but the done-flag is still set (releases the MEM stall).

## Timing
- Reset values: state IDLE, owner INST, kill 0, both done-flags 0, `bus_req` 0, `bus_wr` 0, `bus_size` 0, `bus_addr`/`bus_wdata` 0, both rdata outputs 0.
- Minimum transaction, request seen in IDLE at cycle 0:
  - cycle 1: ADDR with `bus_addr_ok`
  - cycle 2: WAIT with `bus_data_ok`
  - cycle 3: done = 1, stall request low, rdata valid
- Latency is 3 cycles plus bus wait states.
- With both requesters pending, INST waits for the full DATA transaction plus one IDLE cycle.
- Reset mid-transaction: the FSM returns to IDLE at once. The bus bridge is reset by the same `rst`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Add a last-grant register, reset to INST.
  - When both requesters are pending in IDLE, grant the one not granted last.
- Not defined: fixed priority, DATA always wins. The last-grant register is omitted.

## Structure
- Put the state encodings (IDLE/ADDR/WAIT), owner encodings and size codes (BYTE/HALF/WORD) in the shared `defines.vh`.
- One sub-module, `arb_result_hold`, instantiated twice (inst and data). Each instance holds the done-flag and result register, with set/clear/flush inputs.

## Test plan
- Single fetch, addr 0xBFC00000, zero-wait bus returning 0x3C1D0001:
  - `stallreq_from_if` high in cycles 0–2, low in cycle 3.
  - `inst_rdata` = 0x3C1D0001.
- `inst_req` and `data_req` (load, 0x80001000) in the same cycle, fixed priority:
  - First bus address 0x80001000.
  - Fetch address issued only after the data done-flag sets.
  - With `MEM_ARB_ROUND_ROBIN_EN` and last grant = DATA, the fetch goes first.
- `flush` pulse while in WAIT for a load:
  - data_ok is consumed; `data_rdata` is unchanged and the done-flag stays 0.
  - The next request is granted from IDLE.
- Done with `cpu_stall` held high 4 cycles by another source:
  - done-flag and rdata held all 4 cycles; cleared on the first low edge.
- Store, size 0, addr 0x1F, wdata 0xAB, `bus_addr_ok` delayed 3 cycles:
  - `bus_req` held with stable fields all 3 cycles.
  - `bus_wr` = 1, `bus_size` = 0.
- `rst` asserted while in ADDR:
  - Next cycle: `bus_req` = 0, state IDLE, done-flags 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, transaction
// owner, bus size codes, the latched bus command and small helpers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Command presented on the bus while in ADDR; latched at grant time so the
  // requester may change its inputs while the transaction is in flight.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  // The reserved size code 3 is issued as a full word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    logic [1:0] res;
    case (size)
      SIZE_BYTE: res = SIZE_BYTE;
      SIZE_HALF: res = SIZE_HALF;
      default:   res = SIZE_WORD;
    endcase
    return res;
  endfunction

  // Chooses the owner of the next transaction. Only meaningful when at least
  // one requester is pending; prefer_inst breaks the tie when both are.
  function automatic arb_owner_e pick_owner(input logic inst_pend,
                                            input logic data_pend,
                                            input logic prefer_inst);
    arb_owner_e res;
    if (inst_pend && data_pend) begin
      res = prefer_inst ? OWN_INST : OWN_DATA;
    end else if (data_pend) begin
      res = OWN_DATA;
    end else begin
      res = OWN_INST;
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_result_hold.sv
// Holds one requester's returned word and its done-flag until the stalled
// pipeline advances. Set wins over clear so a word that lands while the
// pipeline is moving is still seen for one full cycle.
module arb_result_hold (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_set,
  input  logic        i_load,
  input  logic        i_clr,
  input  logic        i_flush,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata
);

  logic        r_done;
  logic [31:0] r_rdata;

  // Done-flag: set on a completed transaction, cleared on advance or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else if (i_set) begin
      r_done <= 1'b1;
    end else if (i_clr || i_flush) begin
      r_done <= 1'b0;
    end
  end

  // Result word: only reads capture; stores leave the previous word in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else if (i_load) begin
      r_rdata <= i_wdata;
    end
  end

  assign o_done  = r_done;
  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single SRAM-like memory port between instruction fetch and the
// data stage, one outstanding transaction at a time, and raises the stall
// requests that hold each stage until its word has come back.
//
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN
//   defined     - alternate grants when both requesters are pending
//   not defined - fixed priority, the data requester always wins
//
// state | meaning
// IDLE  | no transaction; grant the next pending requester unless flushing
// ADDR  | bus_req high with latched fields, waiting for bus_addr_ok
// WAIT  | address accepted, waiting for bus_data_ok
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  input  logic        cpu_stall,
  input  logic        flush,
  output logic        stallreq_from_if,
  output logic        stallreq_from_mem,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  arb_owner_e r_owner;
  arb_owner_e w_owner_nxt;
  logic       r_kill;
  logic       w_kill_nxt;
  bus_cmd_t   r_cmd;
  bus_cmd_t   w_cmd_nxt;

  logic w_inst_done;
  logic w_data_done;
  logic w_inst_pend;
  logic w_data_pend;
  logic w_prefer_inst;
  logic w_data_ok_live;
  logic w_discard;
  logic w_inst_set;
  logic w_data_set;
  logic w_data_load;
  logic w_advance;

  assign w_inst_pend = inst_req & ~w_inst_done;
  assign w_data_pend = data_req & ~w_data_done;

  assign stallreq_from_if  = w_inst_pend;
  assign stallreq_from_mem = w_data_pend;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_e r_last_grant;

  // Remember who was granted last so a tie goes to the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= OWN_INST;
    end else if (r_state == ST_IDLE && w_state_nxt == ST_ADDR) begin
      r_last_grant <= w_owner_nxt;
    end
  end

  assign w_prefer_inst = (r_last_grant == OWN_DATA);
`else
  assign w_prefer_inst = 1'b0;
`endif

  // A flush in the same cycle as the returning data discards it as well, so
  // a killed word can never reach a result register.
  assign w_data_ok_live = (r_state == ST_WAIT) & bus_data_ok;
  assign w_discard      = r_kill | flush;
  assign w_inst_set     = w_data_ok_live & ~w_discard & (r_owner == OWN_INST);
  assign w_data_set     = w_data_ok_live & ~w_discard & (r_owner == OWN_DATA);
  assign w_data_load    = w_data_set & ~r_cmd.wr;
  assign w_advance      = ~cpu_stall;

  // State, owner, kill and latched command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_INST;
      r_kill  <= 1'b0;
      r_cmd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_kill  <= w_kill_nxt;
      r_cmd   <= w_cmd_nxt;
    end
  end

  // Next-state, grant selection and bus request.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_kill_nxt  = r_kill;
    w_cmd_nxt   = r_cmd;
    bus_req     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!flush && (w_inst_pend || w_data_pend)) begin
          w_owner_nxt = pick_owner(w_inst_pend, w_data_pend, w_prefer_inst);
          w_state_nxt = ST_ADDR;
          if (w_owner_nxt == OWN_DATA) begin
            w_cmd_nxt.wr    = data_wr;
            w_cmd_nxt.size  = norm_size(data_size);
            w_cmd_nxt.addr  = data_addr;
            w_cmd_nxt.wdata = data_wdata;
          end else begin
            w_cmd_nxt.wr    = 1'b0;
            w_cmd_nxt.size  = SIZE_WORD;
            w_cmd_nxt.addr  = inst_addr;
            w_cmd_nxt.wdata = 32'd0;
          end
        end
      end
      ST_ADDR: begin
        bus_req = 1'b1;
        if (flush) begin
          w_kill_nxt = 1'b1;
        end
        if (bus_addr_ok) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The transaction is always drained; kill only suppresses the result.
        if (bus_data_ok) begin
          w_state_nxt = ST_IDLE;
          w_kill_nxt  = 1'b0;
        end else if (flush) begin
          w_kill_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus_wr    = r_cmd.wr;
  assign bus_size  = r_cmd.size;
  assign bus_addr  = r_cmd.addr;
  assign bus_wdata = r_cmd.wdata;

  arb_result_hold u_inst_hold (
    .clk     (clk),
    .rst     (rst),
    .i_set   (w_inst_set),
    .i_load  (w_inst_set),
    .i_clr   (w_advance),
    .i_flush (flush),
    .i_wdata (bus_rdata),
    .o_done  (w_inst_done),
    .o_rdata (inst_rdata)
  );

  arb_result_hold u_data_hold (
    .clk     (clk),
    .rst     (rst),
    .i_set   (w_data_set),
    .i_load  (w_data_load),
    .i_clr   (w_advance),
    .i_flush (flush),
    .i_wdata (bus_rdata),
    .o_done  (w_data_done),
    .o_rdata (data_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural bus slave, a scoreboard of
// expected bus commands and returned words, and directed cycle checks.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        cpu_stall;
  logic        flush;
  logic        stallreq_from_if;
  logic        stallreq_from_mem;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  logic        ext_stall;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        chk_wdata;
  } bus_exp_t;

  bus_exp_t    exp_bus[$];
  logic [31:0] exp_inst[$];
  logic [31:0] exp_data[$];
  logic [31:0] sl_rdq[$];

  int sl_addr_wait;
  int sl_data_wait;
  int n_total;
  int n_pass;

  mem_port_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .inst_req          (inst_req),
    .inst_addr         (inst_addr),
    .inst_rdata        (inst_rdata),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_size         (data_size),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_rdata        (data_rdata),
    .cpu_stall         (cpu_stall),
    .flush             (flush),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_mem (stallreq_from_mem),
    .bus_req           (bus_req),
    .bus_wr            (bus_wr),
    .bus_size          (bus_size),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_addr_ok       (bus_addr_ok),
    .bus_data_ok       (bus_data_ok),
    .bus_rdata         (bus_rdata)
  );

  // The hazard unit stalls everything while either stage waits on memory.
  assign cpu_stall = stallreq_from_if | stallreq_from_mem | ext_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic push_bus(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                          input logic [31:0] wdata, input logic chk_wdata);
    bus_exp_t e;
    e.addr = addr; e.wr = wr; e.size = size; e.wdata = wdata; e.chk_wdata = chk_wdata;
    exp_bus.push_back(e);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Bus slave: accepts the address after sl_addr_wait ADDR cycles, returns
  // data sl_data_wait cycles after the cycle following acceptance.
  initial begin
    int  sl_cnt;
    int  sl_dcnt;
    logic sl_busy;
    sl_cnt = 0; sl_dcnt = 0; sl_busy = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      bus_data_ok = 1'b0;
      if (rst) begin
        bus_addr_ok = 1'b0; sl_busy = 1'b0; sl_cnt = 0;
      end else begin
        if (bus_addr_ok) begin
          bus_addr_ok = 1'b0; sl_busy = 1'b1; sl_dcnt = sl_data_wait;
        end
        if (sl_busy) begin
          if (sl_dcnt == 0) begin
            bus_data_ok = 1'b1;
            bus_rdata   = (sl_rdq.size() > 0) ? sl_rdq.pop_front() : 32'd0;
            sl_busy     = 1'b0;
          end else begin
            sl_dcnt--;
          end
        end else if (bus_req) begin
          if (sl_cnt >= sl_addr_wait) begin
            bus_addr_ok = 1'b1; sl_cnt = 0;
          end else begin
            sl_cnt++;
          end
        end else begin
          sl_cnt = 0;
        end
      end
    end
  end

  // Monitor: checks each accepted bus command and each completed request.
  initial begin
    bus_exp_t    e;
    logic [31:0] w;
    logic        prev_if;
    logic        prev_mem;
    prev_if = 1'b0; prev_mem = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!rst) begin
        if (bus_req && bus_addr_ok) begin
          if (exp_bus.size() == 0) begin
            n_total++;
            $display("FAIL bus_unexpected: got addr 0x%08h, no command expected", bus_addr);
          end else begin
            e = exp_bus.pop_front();
            chk("bus_addr", bus_addr, e.addr);
            chk("bus_wr", 32'(bus_wr), 32'(e.wr));
            chk("bus_size", 32'(bus_size), 32'(e.size));
            if (e.chk_wdata) chk("bus_wdata", bus_wdata, e.wdata);
          end
        end
        if (inst_req && !stallreq_from_if && prev_if) begin
          if (exp_inst.size() == 0) begin
            n_total++;
            $display("FAIL inst_unexpected: got 0x%08h, no fetch expected", inst_rdata);
          end else begin
            w = exp_inst.pop_front();
            chk("inst_rdata", inst_rdata, w);
          end
        end
        if (data_req && !stallreq_from_mem && prev_mem) begin
          if (exp_data.size() == 0) begin
            n_total++;
            $display("FAIL data_unexpected: got 0x%08h, no data access expected", data_rdata);
          end else begin
            w = exp_data.pop_front();
            chk("data_rdata", data_rdata, w);
          end
        end
      end
      prev_if  = stallreq_from_if;
      prev_mem = stallreq_from_mem;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] first_addr;
    logic        seen;
    logic        both_done;
    n_total = 0; n_pass = 0;
    rst = 1'b1; inst_req = 1'b0; inst_addr = 32'd0; data_req = 1'b0; data_wr = 1'b0;
    data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0; flush = 1'b0; ext_stall = 1'b0;
    sl_addr_wait = 0; sl_data_wait = 0;

    // Reset state
    repeat (3) nxt();
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_wr", 32'(bus_wr), 32'd0);
    chk("rst_bus_size", 32'(bus_size), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    rst = 1'b0;
    nxt();

    // Single fetch, zero-wait bus
    push_bus(32'hBFC0_0000, 1'b0, 2'd2, 32'd0, 1'b0);
    sl_rdq.push_back(32'h3C1D_0001);
    exp_inst.push_back(32'h3C1D_0001);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; #1;
    chk("f1_stall_c0", 32'(stallreq_from_if), 32'd1);
    nxt();
    chk("f1_stall_c1", 32'(stallreq_from_if), 32'd1);
    chk("f1_bus_req_c1", 32'(bus_req), 32'd1);
    nxt();
    chk("f1_stall_c2", 32'(stallreq_from_if), 32'd1);
    nxt();
    chk("f1_stall_c3", 32'(stallreq_from_if), 32'd0);
    chk("f1_rdata_c3", inst_rdata, 32'h3C1D_0001);
    inst_req = 1'b0;
    nxt();

    // Simultaneous fetch and load: data first, fetch after one IDLE cycle
    push_bus(32'h8000_1000, 1'b0, 2'd2, 32'd0, 1'b0);
    push_bus(32'hBFC0_0008, 1'b0, 2'd2, 32'd0, 1'b0);
    sl_rdq.push_back(32'h1111_2222);
    sl_rdq.push_back(32'h3C08_0000);
    exp_data.push_back(32'h1111_2222);
    exp_inst.push_back(32'h3C08_0000);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_1000;
    nxt();
    chk("p_first_addr", bus_addr, 32'h8000_1000);
    nxt();
    nxt();
    chk("p_c3_bus_req", 32'(bus_req), 32'd0);
    chk("p_c3_mem_stall", 32'(stallreq_from_mem), 32'd0);
    chk("p_c3_if_stall", 32'(stallreq_from_if), 32'd1);
    nxt();
    chk("p_c4_bus_req", 32'(bus_req), 32'd1);
    chk("p_c4_addr", bus_addr, 32'hBFC0_0008);
    nxt();
    nxt();
    chk("p_c6_if_stall", 32'(stallreq_from_if), 32'd0);
    chk("p_c6_data_hold", data_rdata, 32'h1111_2222);
    inst_req = 1'b0; data_req = 1'b0;
    nxt();

    // Flush while waiting for load data: result discarded, then re-granted
    push_bus(32'h8000_2000, 1'b0, 2'd2, 32'd0, 1'b0);
    push_bus(32'h8000_2000, 1'b0, 2'd2, 32'd0, 1'b0);
    sl_rdq.push_back(32'hDEAD_BEEF);
    sl_rdq.push_back(32'h5566_7788);
    exp_data.push_back(32'h5566_7788);
    sl_data_wait = 2;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_2000;
    nxt();
    nxt();
    chk("fl_c2_bus_req", 32'(bus_req), 32'd0);
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    nxt();
    chk("fl_c4_data_ok", 32'(bus_data_ok), 32'd1);
    sl_data_wait = 0;
    nxt();
    chk("fl_c5_mem_stall", 32'(stallreq_from_mem), 32'd1);
    chk("fl_c5_rdata_kept", data_rdata, 32'h1111_2222);
    chk("fl_c5_bus_req", 32'(bus_req), 32'd0);
    nxt();
    chk("fl_c6_bus_req", 32'(bus_req), 32'd1);
    nxt();
    nxt();
    chk("fl_c8_mem_stall", 32'(stallreq_from_mem), 32'd0);
    data_req = 1'b0;
    nxt();

    // Done held under an external stall for 4 cycles, cleared on first low edge
    push_bus(32'hBFC0_0004, 1'b0, 2'd2, 32'd0, 1'b0);
    sl_rdq.push_back(32'h8FBF_0010);
    exp_inst.push_back(32'h8FBF_0010);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004; ext_stall = 1'b1;
    nxt();
    nxt();
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("hold_if_stall", 32'(stallreq_from_if), 32'd0);
      chk("hold_rdata", inst_rdata, 32'h8FBF_0010);
    end
    ext_stall = 1'b0;
    nxt();
    chk("hold_cleared", 32'(stallreq_from_if), 32'd1);
    inst_req = 1'b0;
    nxt();

    // Byte store with address acceptance delayed 3 cycles
    push_bus(32'h0000_001F, 1'b1, 2'd0, 32'h0000_00AB, 1'b1);
    sl_rdq.push_back(32'hFFFF_FFFF);
    exp_data.push_back(32'h5566_7788);
    sl_addr_wait = 3;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h0000_001F;
    data_wdata = 32'h0000_00AB;
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk("st_bus_req", 32'(bus_req), 32'd1);
      chk("st_bus_addr", bus_addr, 32'h0000_001F);
      chk("st_bus_wdata", bus_wdata, 32'h0000_00AB);
      chk("st_bus_wr", 32'(bus_wr), 32'd1);
      chk("st_bus_size", 32'(bus_size), 32'd0);
    end
    nxt();
    sl_addr_wait = 0;
    nxt();
    nxt();
    chk("st_mem_stall", 32'(stallreq_from_mem), 32'd0);
    data_req = 1'b0; data_wr = 1'b0; data_wdata = 32'd0;
    nxt();

    // Tie after a data grant: round robin picks the fetch, fixed picks data
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_bus(32'hBFC0_0010, 1'b0, 2'd2, 32'd0, 1'b0);
    push_bus(32'h8000_3000, 1'b0, 2'd2, 32'd0, 1'b0);
    sl_rdq.push_back(32'h2408_0005);
    sl_rdq.push_back(32'h1234_5678);
`else
    push_bus(32'h8000_3000, 1'b0, 2'd2, 32'd0, 1'b0);
    push_bus(32'hBFC0_0010, 1'b0, 2'd2, 32'd0, 1'b0);
    sl_rdq.push_back(32'h1234_5678);
    sl_rdq.push_back(32'h2408_0005);
`endif
    exp_inst.push_back(32'h2408_0005);
    exp_data.push_back(32'h1234_5678);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_3000;
    seen = 1'b0; both_done = 1'b0; first_addr = 32'd0;
    for (int k = 0; k < 30; k++) begin
      nxt();
      if (bus_req && !seen) begin
        first_addr = bus_addr; seen = 1'b1;
      end
      if (!stallreq_from_if && !stallreq_from_mem) begin
        both_done = 1'b1;
        break;
      end
    end
    chk("tie_both_done", 32'(both_done), 32'd1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie_first_addr", first_addr, 32'hBFC0_0010);
`else
    chk("tie_first_addr", first_addr, 32'h8000_3000);
`endif
    inst_req = 1'b0; data_req = 1'b0;
    nxt();

    // Reset while in ADDR
    sl_addr_wait = 5;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0020;
    nxt();
    chk("rs_c1_bus_req", 32'(bus_req), 32'd1);
    rst = 1'b1; data_req = 1'b1; data_addr = 32'h8000_4000;
    nxt();
    chk("rs_bus_req", 32'(bus_req), 32'd0);
    chk("rs_if_done_clr", 32'(stallreq_from_if), 32'd1);
    chk("rs_mem_done_clr", 32'(stallreq_from_mem), 32'd1);
    chk("rs_inst_rdata", inst_rdata, 32'd0);
    chk("rs_data_rdata", data_rdata, 32'd0);
    chk("rs_bus_addr", bus_addr, 32'd0);
    rst = 1'b0; inst_req = 1'b0; data_req = 1'b0; sl_addr_wait = 0;
    repeat (3) nxt();

    chk("sb_bus_empty", 32'(exp_bus.size()), 32'd0);
    chk("sb_inst_empty", 32'(exp_inst.size()), 32'd0);
    chk("sb_data_empty", 32'(exp_data.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
